// File: rtl/snn_axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : snn_axi_pkg                                              |
// | Brief   : Shared constants and types for the SNN result reader.    |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package snn_axi_pkg;

  // AXI read responses
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  // Word offsets inside the register window (low nibble only)
  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_RESULT = 4'h4;
  localparam logic [3:0] OFF_LAST   = 4'h8;
  localparam logic [3:0] OFF_COUNT  = 4'hC;

  // STATUS / RESULT bit positions
  localparam int STS_OVF_BIT   = 31;
  localparam int STS_EMPTY_BIT = 30;
  localparam int STS_FULL_BIT  = 29;
  localparam int RES_VALID_BIT = 31;

  // Read handshake state
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } hs_state_e;

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : result_fifo                                              |
// | Brief   : Small synchronous FIFO; push while full is dropped       |
// |           unless a pop happens in the same cycle.                  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Accept/commit decisions and next pointer/count values
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_result_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : axi_lite_result_reader                                   |
// | Brief   : AXI4-Lite read-only slave returning SNN inference        |
// |           results via a capture FIFO and a small register window.  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module axi_lite_result_reader
  import snn_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned WIN_BYTES  = 32,
  parameter int unsigned DIGIT_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        ARADDR,
  input  logic [2:0]         ARPROT,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RVALID,
  input  logic               RREADY,
  input  logic               COPROCESSOR_RDY,
  input  logic [DIGIT_W-1:0] INFERED_DIGIT
);

  localparam logic [31:0] WIN_SIZE = 32'(WIN_BYTES);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  hs_state_e          state_q, state_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rdy_q;
  logic               overflow_q, overflow_d;
  logic [DIGIT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   total_q, total_d;

  logic [31:0]        off;
  logic [3:0]         reg_off;
  logic               in_win, low_reg, ar_hs;
  logic               sel_status, sel_result;
  logic               push, pop;
  logic [31:0]        rd_word;

  logic [DIGIT_W-1:0] fifo_dout;
  logic               fifo_empty, fifo_full;
  logic [FCW-1:0]     fifo_count;
  logic               unused_ok;

  result_fifo #(
    .WIDTH (DIGIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (push),
    .pop   (pop),
    .din   (INFERED_DIGIT),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Address decode; byte lane bits are ignored and the base is word aligned
  always_comb begin
    off        = ARADDR - BASE_ADDR;
    in_win     = (off < WIN_SIZE);
    low_reg    = (off[31:4] == '0);
    reg_off    = {off[3:2], 2'b00};
    ar_hs      = (state_q == IDLE) && ARVALID;
    sel_status = ar_hs && in_win && low_reg && (reg_off == OFF_STATUS);
    sel_result = ar_hs && in_win && low_reg && (reg_off == OFF_RESULT);
  end

  // Read data multiplexer, evaluated against pre-side-effect state
  always_comb begin
    rd_word = '0;
    if (in_win && low_reg) begin
      case (reg_off)
        OFF_STATUS: begin
          rd_word[STS_OVF_BIT]   = overflow_q;
          rd_word[STS_EMPTY_BIT] = fifo_empty;
          rd_word[STS_FULL_BIT]  = fifo_full;
          rd_word[15:0]          = 16'(fifo_count);
        end
        OFF_RESULT: begin
          if (!fifo_empty) begin
            rd_word[RES_VALID_BIT] = 1'b1;
            rd_word[15:0]          = 16'(fifo_dout);
          end
        end
        OFF_LAST:  rd_word = 32'(last_q);
        OFF_COUNT: rd_word = 32'(total_q);
        default:   rd_word = '0;
      endcase
    end
  end

  // Capture path and read side effects; a same-cycle overflow beats the STATUS clear
  always_comb begin
    push       = COPROCESSOR_RDY && !rdy_q;
    pop        = sel_result && !fifo_empty;
    overflow_d = overflow_q;
    if (sel_status) begin
      overflow_d = 1'b0;
    end
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
    last_d  = push ? INFERED_DIGIT : last_q;
    total_d = push ? total_q + CNT_W'(1) : total_q;
  end

  // AR/R handshake next-state and response registers
  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (state_q)
      IDLE: begin
        if (ARVALID) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
          rresp_d  = in_win ? RRESP_OKAY : RRESP_SLVERR;
        end
      end
      RESP: begin
        if (RREADY) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RRESP_OKAY;
      rdy_q      <= 1'b0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rdy_q      <= COPROCESSOR_RDY;
      overflow_q <= overflow_d;
      last_q     <= last_d;
      total_q    <= total_d;
    end
  end

  assign ARREADY   = (state_q == IDLE);
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign unused_ok = ^{ARPROT, off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_result_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_axi_lite_result_reader                                |
// | Brief   : Self-checking bench: queue-based reference model plus    |
// |           directed reads with hand-computed expectations.          |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_axi_lite_result_reader;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          WIN   = 32;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        COPROCESSOR_RDY = 1'b0;
  logic [7:0]  INFERED_DIGIT = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_result_reader #(
    .BASE_ADDR  (BASE),
    .WIN_BYTES  (WIN),
    .DIGIT_W    (8),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (16)
  ) dut (
    .ACLK            (clk),
    .ARESETN         (ARESETN),
    .ARADDR          (ARADDR),
    .ARPROT          (ARPROT),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .RDATA           (RDATA),
    .RRESP           (RRESP),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .COPROCESSOR_RDY (COPROCESSOR_RDY),
    .INFERED_DIGIT   (INFERED_DIGIT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          q[$];
  bit          m_ovf, m_busy, m_rdy_prev, started;
  int          m_last, m_total;
  logic [31:0] m_rdata, nd;
  logic [1:0]  m_rresp, nr;
  bit          m_push, m_hs, m_pop, m_clr;

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                     output logic [1:0] r, output bit pop, output bit clr);
    longint a;
    longint off;
    a = longint'(addr);
    d = '0; r = 2'b00; pop = 0; clr = 0;
    if (a < longint'(BASE) || a >= longint'(BASE) + WIN) begin
      r = 2'b10;
      return;
    end
    off = (a - longint'(BASE)) / 4 * 4;
    case (off)
      0: begin
        d = 32'(q.size());
        if (m_ovf) d[31] = 1'b1;
        if (q.size() == 0) d[30] = 1'b1;
        if (q.size() == DEPTH) d[29] = 1'b1;
        clr = 1;
      end
      4: if (q.size() > 0) begin
        d = 32'h8000_0000 | 32'(q[0]);
        pop = 1;
      end
      8:  d = 32'(m_last);
      12: d = 32'(m_total);
      default: d = '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ARESETN) begin
      q.delete();
      m_ovf = 0; m_busy = 0; m_rdy_prev = 0;
      m_last = 0; m_total = 0; m_rdata = '0; m_rresp = 2'b00;
      started = 1;
    end else begin
      m_push = COPROCESSOR_RDY && !m_rdy_prev;
      m_rdy_prev = COPROCESSOR_RDY;
      m_hs = !m_busy && ARVALID;
      m_pop = 0; m_clr = 0;
      if (m_hs) model_read(ARADDR, nd, nr, m_pop, m_clr);
      if (m_busy && RREADY) m_busy = 0;
      if (m_hs) begin
        m_busy = 1; m_rdata = nd; m_rresp = nr;
      end
      if (m_pop) void'(q.pop_front());
      if (m_clr) m_ovf = 0;
      if (m_push) begin
        m_last = int'(INFERED_DIGIT);
        m_total = (m_total + 1) % 65536;
        if (q.size() < DEPTH) q.push_back(int'(INFERED_DIGIT));
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("arready", 32'(ARREADY), 32'(!m_busy));
      chk("rvalid", 32'(RVALID), 32'(m_busy));
      if (m_busy) begin
        chk("rdata", RDATA, m_rdata);
        chk("rresp", 32'(RRESP), 32'(m_rresp));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; ARVALID = 1'b0; RREADY = 1'b0; COPROCESSOR_RDY = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
  endtask

  task automatic pulse(input logic [7:0] dig, input int len);
    INFERED_DIGIT = dig;
    COPROCESSOR_RDY = 1'b1;
    repeat (len) tick();
    COPROCESSOR_RDY = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [31:0] addr, input int hold, input bit poke,
                    output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    hs = 0; n = 0;
    ARADDR = addr; ARVALID = 1'b1; RREADY = (hold == 0);
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = ARREADY;
      @(posedge clk); #2;
      n++;
    end
    ARVALID = 1'b0;
    if (!hs) chk("ar_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("rvalid_latency", 32'(RVALID), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("arready_busy", 32'(ARREADY), 32'd0);
      @(posedge clk); #2;
      if (poke) begin
        ARVALID = 1'b1;
        ARADDR  = BASE + 32'h8;
      end
      @(negedge clk);
    end
    RREADY = 1'b1;
    n = 0;
    while (!RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!RVALID) chk("r_timeout", 32'd0, 32'd1);
    data = RDATA;
    resp = RRESP;
    @(posedge clk); #2;
    RREADY = 1'b0;
    ARVALID = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    do_reset();
    rd(BASE, 0, 0, d, r);
    chk("t1_status", d, 32'h4000_0000);
    chk("t1_resp", 32'(r), 32'd0);

    // 2: two results, first one with a held ready level
    pulse(8'd3, 3);
    pulse(8'd7, 1);
    rd(BASE + 32'h0, 0, 0, d, r); chk("t2_status", d, 32'h0000_0002);
    rd(BASE + 32'h8, 0, 0, d, r); chk("t2_last", d, 32'h0000_0007);
    rd(BASE + 32'hC, 0, 0, d, r); chk("t2_count", d, 32'h0000_0002);
    rd(BASE + 32'h4, 0, 0, d, r); chk("t2_res0", d, 32'h8000_0003);
    rd(BASE + 32'h4, 0, 0, d, r); chk("t2_res1", d, 32'h8000_0007);
    rd(BASE + 32'h4, 0, 0, d, r); chk("t2_res2", d, 32'h0000_0000);

    // 3: overflow
    do_reset();
    for (int i = 1; i <= 5; i++) pulse(8'(i), 1);
    rd(BASE, 0, 0, d, r);         chk("t3_status_ovf", d, 32'hA000_0004);
    rd(BASE, 0, 0, d, r);         chk("t3_status_clr", d, 32'h2000_0004);
    rd(BASE + 32'hC, 0, 0, d, r); chk("t3_count", d, 32'h0000_0005);

    // 4: stalled R channel with a pending AR request
    rd(BASE + 32'h8, 5, 1, d, r); chk("t4_last", d, 32'h0000_0005);

    // 5: window boundaries
    rd(32'h0000_3000, 0, 0, d, r); chk("t5_oow_data", d, 32'h0); chk("t5_oow_resp", 32'(r), 32'd2);
    rd(BASE, 0, 0, d, r);          chk("t5_status", d, 32'h2000_0004);
    rd(32'h0000_2010, 0, 0, d, r); chk("t5_hole_data", d, 32'h0); chk("t5_hole_resp", 32'(r), 32'd0);
    rd(32'h0000_201F, 0, 0, d, r); chk("t5_top_resp", 32'(r), 32'd0);
    rd(32'h0000_2020, 0, 0, d, r); chk("t5_end_resp", 32'(r), 32'd2);
    rd(32'h0000_1FFC, 0, 0, d, r); chk("t5_below_resp", 32'(r), 32'd2);
    rd(32'h0000_2006, 0, 0, d, r); chk("t5_unaligned", d, 32'h8000_0001);

    // 6: push colliding with RESULT handshake
    do_reset();
    pulse(8'h09, 1);
    INFERED_DIGIT = 8'h0B; COPROCESSOR_RDY = 1'b1;
    rd(BASE + 32'h4, 0, 0, d, r); chk("t6_old_head", d, 32'h8000_0009);
    COPROCESSOR_RDY = 1'b0; tick();
    rd(BASE, 0, 0, d, r);         chk("t6_count1", d, 32'h0000_0001);
    rd(BASE + 32'h4, 0, 0, d, r); chk("t6_res_b", d, 32'h8000_000B);
    INFERED_DIGIT = 8'h0C; COPROCESSOR_RDY = 1'b1;
    rd(BASE + 32'h4, 0, 0, d, r); chk("t6_empty_nobypass", d, 32'h0);
    COPROCESSOR_RDY = 1'b0; tick();
    rd(BASE, 0, 0, d, r);         chk("t6_stored", d, 32'h0000_0001);
    rd(BASE + 32'h4, 0, 0, d, r); chk("t6_res_c", d, 32'h8000_000C);
    for (int i = 1; i <= 4; i++) pulse(8'(i), 1);
    INFERED_DIGIT = 8'h05; COPROCESSOR_RDY = 1'b1;
    rd(BASE + 32'h4, 0, 0, d, r); chk("t6_full_pop", d, 32'h8000_0001);
    COPROCESSOR_RDY = 1'b0; tick();
    rd(BASE, 0, 0, d, r);         chk("t6_full_noovf", d, 32'h2000_0004);

    // 6b: reset while a response is outstanding
    ARADDR = BASE + 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    @(negedge clk); chk("t6_rvalid_pending", 32'(RVALID), 32'd1);
    ARESETN = 1'b0;
    @(negedge clk); chk("t6_rvalid_reset", 32'(RVALID), 32'd0);
    ARESETN = 1'b1;
    tick();
    rd(BASE, 0, 0, d, r);         chk("t6_status_after_rst", d, 32'h4000_0000);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
